// File: rtl/parking_gate_counter_pkg.sv
// Shared types and constants for the parking gate counter.
// The lot display also uses these.
package parking_pkg;

  localparam int CNT_W    = 5;
  localparam int MAX_CARS = 25;

  typedef enum logic [2:0] {
    IDLE, EN1, EN2, EN3,
    EX1, EX2, EX3, ERR
  } gate_state_t;

endpackage

// File: rtl/parking_gate_counter_if.sv
// Occupancy bundle between the gate counter and the lot display.
// master = gate counter, slave = display/top level.
interface parking_gate_counter_if;
  import parking_pkg::*;

  logic             sensor_a;
  logic             sensor_b;
  logic [CNT_W-1:0] cntNum;
  logic             full;
  logic             empty;
  logic             car_in;
  logic             car_out;
  logic             seq_err;

  modport master (
    input  sensor_a, sensor_b,
    output cntNum, full, empty,
    output car_in, car_out, seq_err
  );

  modport slave (
    output sensor_a, sensor_b,
    input  cntNum, full, empty,
    input  car_in, car_out, seq_err
  );

endinterface

// File: rtl/parking_gate_counter_sensor_filter.sv
// Synchroniser chain followed by a stable-count debouncer.
// The filtered value flips once the synced input differs for DEBOUNCE_CYCLES edges.
module sensor_filter #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic f_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q;
  logic                   f_q;
  logic                   s;

  assign s   = sync_q[SYNC_STAGES-1];
  assign f_o = f_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      cnt_q  <= '0;
      f_q    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      if (s == f_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        cnt_q <= '0;
        f_q   <= s;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/parking_gate_counter.sv
// Gate direction tracker with a saturating occupancy counter.
// Sensor A faces the street, sensor B faces the lot.
module parking_gate_counter #(
  parameter int MAX_CARS        = parking_pkg::MAX_CARS,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic       CLOCK_50,
  input  logic       RSTN,
  input  logic       sensor_a,
  input  logic       sensor_b,
  output logic [4:0] cntNum,
  output logic       full,
  output logic       empty,
  output logic       car_in,
  output logic       car_out,
  output logic       seq_err
);

  import parking_pkg::*;

  localparam logic [CNT_W-1:0] MAXC = CNT_W'(MAX_CARS);

  logic fa, fb;
  logic [1:0] ab;

  gate_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic full_q, full_d, empty_q, empty_d;
  logic in_q, in_d, out_q, out_d, err_q, err_d;
  logic ent, ext, bad;

  sensor_filter #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_filt_a (
    .clk  (CLOCK_50),
    .rst_n(RSTN),
    .d_i  (sensor_a),
    .f_o  (fa)
  );

  sensor_filter #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_filt_b (
    .clk  (CLOCK_50),
    .rst_n(RSTN),
    .d_i  (sensor_b),
    .f_o  (fb)
  );

  assign ab = {fa, fb};

  always_comb begin
    state_d = state_q;
    ent     = 1'b0;
    ext     = 1'b0;
    bad     = 1'b0;
    case (state_q)
      IDLE: case (ab)
        2'b10: state_d = EN1;
        2'b01: state_d = EX1;
        2'b11: begin state_d = ERR; bad = 1'b1; end
        default: ;
      endcase
      EN1: case (ab)
        2'b11: state_d = EN2;
        2'b00: state_d = IDLE;
        2'b01: begin state_d = ERR; bad = 1'b1; end
        default: ;
      endcase
      EN2: case (ab)
        2'b01: state_d = EN3;
        2'b10: state_d = EN1;
        2'b00: begin state_d = ERR; bad = 1'b1; end
        default: ;
      endcase
      EN3: case (ab)
        2'b00: begin state_d = IDLE; ent = 1'b1; end
        2'b11: state_d = EN2;
        2'b10: begin state_d = ERR; bad = 1'b1; end
        default: ;
      endcase
      EX1: case (ab)
        2'b11: state_d = EX2;
        2'b00: state_d = IDLE;
        2'b10: begin state_d = ERR; bad = 1'b1; end
        default: ;
      endcase
      EX2: case (ab)
        2'b10: state_d = EX3;
        2'b01: state_d = EX1;
        2'b00: begin state_d = ERR; bad = 1'b1; end
        default: ;
      endcase
      EX3: case (ab)
        2'b00: begin state_d = IDLE; ext = 1'b1; end
        2'b11: state_d = EX2;
        2'b01: begin state_d = ERR; bad = 1'b1; end
        default: ;
      endcase
      ERR: if (ab == 2'b00) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Saturating count; a blocked entry/exit becomes a sequence error
  always_comb begin
    cnt_d = cnt_q;
    in_d  = 1'b0;
    out_d = 1'b0;
    err_d = bad;
    if (ent) begin
      if (cnt_q < MAXC) begin
        cnt_d = cnt_q + CNT_W'(1);
        in_d  = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
    if (ext) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - CNT_W'(1);
        out_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
    full_d  = (cnt_d == MAXC);
    empty_d = (cnt_d == '0);
  end

  always_ff @(posedge CLOCK_50 or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      in_q    <= 1'b0;
      out_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      in_q    <= in_d;
      out_q   <= out_d;
      err_q   <= err_d;
    end
  end

  assign cntNum  = cnt_q;
  assign full    = full_q;
  assign empty   = empty_q;
  assign car_in  = in_q;
  assign car_out = out_q;
  assign seq_err = err_q;

endmodule

// File: tb/tb_parking_gate_counter.sv
// Scoreboard bench for parking_gate_counter with a short debounce.
// Expected pulses are queued as stimulus is driven, popped when the DUT pulses.
module tb_parking_gate_counter;
  import parking_pkg::*;

  localparam int MAXC = 25;
  localparam int SYNC = 2;
  localparam int DEB  = 4;

  typedef struct packed {
    logic       in;
    logic       out;
    logic       err;
    logic [4:0] cnt;
    logic       full;
    logic       empty;
  } exp_t;

  logic clk;
  logic rst_n;

  parking_gate_counter_if pg ();

  exp_t q[$];
  int   mcnt;
  int   passed;
  int   total;

  parking_gate_counter #(
    .MAX_CARS       (MAXC),
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .CLOCK_50(clk),
    .RSTN    (rst_n),
    .sensor_a(pg.sensor_a),
    .sensor_b(pg.sensor_b),
    .cntNum  (pg.cntNum),
    .full    (pg.full),
    .empty   (pg.empty),
    .car_in  (pg.car_in),
    .car_out (pg.car_out),
    .seq_err (pg.seq_err)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  function automatic exp_t mk(logic i, logic o, logic e, int c);
    exp_t r;
    r.in    = i;
    r.out   = o;
    r.err   = e;
    r.cnt   = 5'(c);
    r.full  = (c == MAXC);
    r.empty = (c == 0);
    return r;
  endfunction

  // Pulse monitor: every pulse must match the head of the scoreboard
  always @(negedge clk) begin
    exp_t got, e;
    if (rst_n && (pg.car_in || pg.car_out || pg.seq_err)) begin
      got = {pg.car_in, pg.car_out, pg.seq_err,
             pg.cntNum, pg.full, pg.empty};
      total++;
      if (q.size() == 0) begin
        $display("FAIL unexpected_pulse got=%b required=none", got);
      end else begin
        e = q.pop_front();
        if (got !== e)
          $display("FAIL pulse got=%b required=%b", got, e);
        else
          passed++;
      end
    end
  end

  task automatic step(input logic a, input logic b);
    pg.sensor_a = a;
    pg.sensor_b = b;
    repeat (10) @(posedge clk);
  endtask

  task automatic do_entry();
    if (mcnt < MAXC) begin
      mcnt++;
      q.push_back(mk(1, 0, 0, mcnt));
    end else begin
      q.push_back(mk(0, 0, 1, mcnt));
    end
    step(1, 0); step(1, 1); step(0, 1); step(0, 0);
  endtask

  task automatic do_exit();
    if (mcnt > 0) begin
      mcnt--;
      q.push_back(mk(0, 1, 0, mcnt));
    end else begin
      q.push_back(mk(0, 0, 1, mcnt));
    end
    step(0, 1); step(1, 1); step(1, 0); step(0, 0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    pg.sensor_a = 1'b0;
    pg.sensor_b = 1'b0;
    repeat (3) @(posedge clk);
    #5 rst_n = 1'b1;
    mcnt = 0;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    total++;
    if (pg.cntNum !== 5'd0)
      $display("FAIL rst_cnt got=%0d required=0", pg.cntNum);
    else passed++;
    total++;
    if ({pg.full, pg.empty} !== 2'b01)
      $display("FAIL rst_flags got=%b required=01", {pg.full, pg.empty});
    else passed++;
    total++;
    if ({pg.car_in, pg.car_out, pg.seq_err} !== 3'b000)
      $display("FAIL rst_pulses got=%b required=000",
               {pg.car_in, pg.car_out, pg.seq_err});
    else passed++;
  endtask

  task automatic test_entry();
    do_entry();
    total++;
    if (q.size() != 0)
      $display("FAIL entry_drain got=%0d required=0", q.size());
    else passed++;
    q.delete();
  endtask

  task automatic test_exit();
    do_entry();
    do_entry();
    do_exit();
    step(1, 0); step(0, 0);
    @(negedge clk);
    total++;
    if (pg.cntNum !== 5'd2)
      $display("FAIL backout_cnt got=%0d required=2", pg.cntNum);
    else passed++;
    total++;
    if (q.size() != 0)
      $display("FAIL exit_drain got=%0d required=0", q.size());
    else passed++;
    q.delete();
  endtask

  task automatic test_full();
    while (mcnt < MAXC) do_entry();
    @(negedge clk);
    total++;
    if ({pg.cntNum, pg.full} !== {5'd25, 1'b1})
      $display("FAIL full_state got=%0d/%b required=25/1",
               pg.cntNum, pg.full);
    else passed++;
    do_entry();
    @(negedge clk);
    total++;
    if (pg.cntNum !== 5'd25)
      $display("FAIL full_sat got=%0d required=25", pg.cntNum);
    else passed++;
    total++;
    if (q.size() != 0)
      $display("FAIL full_drain got=%0d required=0", q.size());
    else passed++;
    q.delete();
  endtask

  task automatic test_empty_err();
    apply_reset();
    do_exit();
    q.push_back(mk(0, 0, 1, 0));
    step(1, 0); step(0, 1);
    @(negedge clk);
    total++;
    if (dut.state_q !== ERR)
      $display("FAIL err_state got=%0d required=%0d", dut.state_q, ERR);
    else passed++;
    step(1, 0); step(1, 1); step(0, 1);
    total++;
    if (dut.state_q !== ERR)
      $display("FAIL err_hold got=%0d required=%0d", dut.state_q, ERR);
    else passed++;
    step(0, 0);
    @(negedge clk);
    total++;
    if (dut.state_q !== IDLE || pg.cntNum !== 5'd0)
      $display("FAIL err_exit got=%0d/%0d required=%0d/0",
               dut.state_q, pg.cntNum, IDLE);
    else passed++;
    total++;
    if (q.size() != 0)
      $display("FAIL empty_drain got=%0d required=0", q.size());
    else passed++;
    q.delete();
  endtask

  task automatic test_glitch();
    int  n;
    logic seen;
    @(posedge clk);
    #1 pg.sensor_a = 1'b1;
    repeat (2) @(posedge clk);
    #1 pg.sensor_a = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (dut.u_filt_a.f_o !== 1'b0 || dut.state_q !== IDLE) seen = 1'b1;
    end
    total++;
    if (seen)
      $display("FAIL glitch got=moved required=stable");
    else passed++;
    @(posedge clk);
    #1 pg.sensor_a = 1'b1;
    n = 0;
    while (dut.u_filt_a.f_o !== 1'b1 && n < 50) begin
      @(posedge clk);
      #1 n++;
    end
    total++;
    if (n != SYNC + DEB)
      $display("FAIL latency got=%0d required=%0d", n, SYNC + DEB);
    else passed++;
    step(1, 0);
    step(0, 0);
    total++;
    if (q.size() != 0 || dut.state_q !== IDLE)
      $display("FAIL glitch_idle got=%0d required=%0d", dut.state_q, IDLE);
    else passed++;
  endtask

  task automatic test_reset_mid();
    repeat (7) do_entry();
    step(1, 0); step(1, 1);
    @(negedge clk);
    total++;
    if (dut.state_q !== EN2 || pg.cntNum !== 5'd7)
      $display("FAIL pre_rst got=%0d/%0d required=%0d/7",
               dut.state_q, pg.cntNum, EN2);
    else passed++;
    @(posedge clk);
    #5 rst_n = 1'b0;
    #2;
    total++;
    if ({pg.cntNum, pg.full, pg.empty,
         pg.car_in, pg.car_out, pg.seq_err} !== {5'd0, 5'b01000})
      $display("FAIL async_rst got=%0d/%b required=0/01000", pg.cntNum,
               {pg.full, pg.empty, pg.car_in, pg.car_out, pg.seq_err});
    else passed++;
    total++;
    if (dut.state_q !== IDLE)
      $display("FAIL async_rst_state got=%0d required=%0d",
               dut.state_q, IDLE);
    else passed++;
    #30 rst_n = 1'b1;
    mcnt = 0;
    q.push_back(mk(0, 0, 1, 0));
    repeat (10) @(posedge clk);
    step(0, 1); step(0, 0);
    @(negedge clk);
    total++;
    if (pg.cntNum !== 5'd0)
      $display("FAIL post_rst_cnt got=%0d required=0", pg.cntNum);
    else passed++;
    total++;
    if (q.size() != 0)
      $display("FAIL post_rst_drain got=%0d required=0", q.size());
    else passed++;
    q.delete();
  endtask

  initial begin
    passed = 0;
    total  = 0;
    mcnt   = 0;
    rst_n  = 1'b0;
    pg.sensor_a = 1'b0;
    pg.sensor_b = 1'b0;
    test_reset();
    test_entry();
    test_exit();
    test_full();
    test_empty_err();
    test_glitch();
    test_reset_mid();
    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/parking_gate_counter.md
Name: parking_gate_counter

Overview:
- Producer side of the 5-bit occupancy interface consumed by the lot display.
- Watches two gate photo-sensors: A on the outer/street side, B on the inner/lot side.
- Each sensor is synchronised and debounced; a direction-tracking FSM then classifies complete enter and exit sequences.
- Maintains a saturating car count 0..MAX_CARS and drives cntNum, status flags and event pulses to the display and top level.

Parameters:
- MAX_CARS, 25: lot capacity; count saturates here.
- SYNC_STAGES, 2: flip-flop synchroniser depth per sensor (minimum 2).
- DEBOUNCE_CYCLES, 50000: consecutive stable clock cycles required before a sensor change is accepted (1 ms at 50 MHz); minimum 1.

Ports:
- CLOCK_50  input  1  system clock, 50 MHz
- RSTN  input  1  asynchronous active-low reset
- sensor_a  input  1  outer beam blocked (1), asynchronous to clock
- sensor_b  input  1  inner beam blocked (1), asynchronous to clock
- cntNum  output  5  current occupancy, 0..MAX_CARS
- full  output  1  cntNum == MAX_CARS
- empty  output  1  cntNum == 0
- car_in  output  1  one-cycle pulse: valid entry counted
- car_out  output  1  one-cycle pulse: valid exit counted
- seq_err  output  1  one-cycle pulse: illegal sensor sequence, or entry while full, or exit while empty

Behaviour:
- Reset (RSTN low, asynchronous):
  - cntNum=0, empty=1, full=0.
  - car_in, car_out and seq_err are all 0.
  - FSM is in IDLE.
  - Synchroniser and filtered values are 0; debounce counters are 0.
- Release of reset is used synchronously, i.e. the first active edge after RSTN rises.
- Sync: each sensor passes through a SYNC_STAGES flip-flop chain.
- Debounce, per sensor:
  - The filtered value f changes only after the synced value s differs from f for DEBOUNCE_CYCLES consecutive edges.
  - f takes the new value on the edge the counter reaches DEBOUNCE_CYCLES.
  - Any edge with s==f clears the counter.
  - Input-change to f-change latency is SYNC_STAGES+DEBOUNCE_CYCLES cycles.
- FSM input is the pair {fa,fb}. States and transitions (any pair not listed keeps the current state):
  - IDLE: 10 -> EN1; 01 -> EX1; 11 -> ERR with seq_err pulse.
  - EN1: 11 -> EN2; 00 -> IDLE (car backed out, no count); 01 -> ERR with seq_err.
  - EN2: 01 -> EN3; 10 -> EN1 (backing up); 00 -> ERR with seq_err.
  - EN3: 00 -> IDLE and count entry; 11 -> EN2; 10 -> ERR with seq_err.
  - EX1/EX2/EX3: mirror of EN1/EN2/EN3 with A and B swapped; EX3 on 00 -> IDLE and count exit.
  - ERR: remain until 00, then -> IDLE; no further pulses while in ERR.
- Counting, all on the same edge as the completing FSM transition:
  - Entry with cntNum<MAX_CARS: cntNum+1, car_in=1 for one cycle.
  - Entry with cntNum==MAX_CARS: cntNum unchanged, car_in=0, seq_err=1.
  - Exit with cntNum>0: cntNum-1, car_out=1.
  - Exit with cntNum==0: cntNum unchanged, seq_err=1.
  - full and empty are registered and change on the same edge as cntNum.
  - Count arithmetic is 5-bit unsigned; saturation means no wrap at 0 or MAX_CARS.
- Pulse rules:
  - Only one FSM completion per cycle, so car_in and car_out are never both high.
  - seq_err may coincide with neither.
- Reset mid-sequence: FSM returns to IDLE and the count is cleared. A car in the beam after reset is tracked from whatever filtered state follows; a sequence starting mid-beam ends in ERR or is ignored, never counted.

Decomposition:
- Shared package parking_pkg holds:
  - the gate_state_t enum (IDLE, EN1, EN2, EN3, EX1, EX2, EX3, ERR);
  - CNT_W=5;
  - the default MAX_CARS=25, also used by the display to select its "FULL" message.
- Sub-module sensor_filter (sync chain plus debounce, parameters SYNC_STAGES and DEBOUNCE_CYCLES) is instantiated twice, once per sensor.
- FSM and counter stay in the top module.

Test Plan (bench overrides DEBOUNCE_CYCLES=4; the sensor sequences below are each held 10 cycles per step):
- Reset, then A/B = 10,11,01,00 -> exactly one car_in pulse; cntNum 0->1; empty 1->0 on the same edge.
- From cntNum=3, A/B = 01,11,10,00 -> one car_out pulse; cntNum=2. Also 10,00 (backout) -> no pulse, count stays 2.
- 25 full entries -> cntNum=25, full=1. A 26th entry -> seq_err pulse, cntNum stays 25, no car_in.
- From empty, a complete exit sequence -> seq_err, cntNum stays 0. Then 10,01 (illegal jump) -> seq_err, FSM in ERR, no count until 00.
- Glitch: a 2-cycle high on sensor_a -> filtered value never changes, no FSM movement. A steady change -> filtered value updates exactly SYNC_STAGES+4 cycles after the input.
- Assert RSTN low while in EN2 with cntNum=7 -> all outputs reach reset values immediately, without waiting for a clock edge. After release, the completing 01,00 produces no car_in.
